// File: rtl/sum_stream_accumulator_pkg.sv
// Shared FSM state type and default parameter values for the sum stream accumulator.
package sum_stream_accumulator_pkg;

  localparam int DEFAULT_WIDTH     = 8;
  localparam int DEFAULT_GROUP_LEN = 4;
  localparam int DEFAULT_OUT_WIDTH = 10;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_stream_accumulator_if.sv
// Beat input and group-result output handshakes of the sum stream accumulator.
interface sum_stream_accumulator_if
  import sum_stream_accumulator_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int out_width = DEFAULT_OUT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [width-1:0]     in_data;
  logic                 out_valid;
  logic                 out_ready;
  logic [out_width-1:0] out_data;
  logic                 out_overflow;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_overflow
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_overflow
  );

endinterface

// File: rtl/sum_stream_acc_adder.sv
// Accumulator add stage; wraps by default, saturates when SUM_STREAM_ACCUMULATOR_SATURATE_EN is defined.
module sum_stream_acc_adder
  import sum_stream_accumulator_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int out_width = DEFAULT_OUT_WIDTH
) (
  input  logic [out_width-1:0] acc,
  input  logic [width-1:0]     beat,
  output logic [out_width-1:0] sum,
  output logic                 overflow
);

  localparam int wide_w = out_width + 1;

  logic [out_width:0] wide;

  // The extra top bit is the carry out; it flags overflow in both modes.
  always_comb begin
    wide     = {1'b0, acc} + wide_w'(beat);
    overflow = wide[out_width];
`ifdef SUM_STREAM_ACCUMULATOR_SATURATE_EN
    sum      = overflow ? '1 : wide[out_width-1:0];
`else
    sum      = wide[out_width-1:0];
`endif
  end

endmodule

// File: rtl/sum_stream_accumulator.sv
// Sums group_len unsigned beats per group and presents the total with an overflow flag.
// Overflow handling is selected by SUM_STREAM_ACCUMULATOR_SATURATE_EN (wrap when undefined).
module sum_stream_accumulator
  import sum_stream_accumulator_pkg::*;
#(
  parameter int width     = DEFAULT_WIDTH,
  parameter int group_len = DEFAULT_GROUP_LEN,
  parameter int out_width = DEFAULT_OUT_WIDTH
) (
  input logic                   clk,
  input logic                   rst,
  sum_stream_accumulator_if.slave port
);

  localparam int count_w = $clog2(group_len);
  localparam logic [count_w-1:0] last_count = count_w'(group_len - 1);

  if (group_len < 2 || group_len > 256 || out_width < width) begin : g_bad_params
    $error("sum_stream_accumulator: illegal parameter combination");
  end

  state_t               state;
  logic [out_width-1:0] acc;
  logic [count_w-1:0]   count;
  logic                 sticky_ovf;
  logic                 out_valid_q;
  logic [out_width-1:0] out_data_q;
  logic                 out_overflow_q;
  logic [out_width-1:0] sum;
  logic                 add_ovf;

  sum_stream_acc_adder #(
    .width     (width),
    .out_width (out_width)
  ) adder (
    .acc      (acc),
    .beat     (port.in_data),
    .sum      (sum),
    .overflow (add_ovf)
  );

  // While holding a result, a beat may only enter when the result leaves in the same cycle.
  assign port.in_ready     = (state == ACCUM) | port.out_ready;
  assign port.out_valid    = out_valid_q;
  assign port.out_data     = out_data_q;
  assign port.out_overflow = out_overflow_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= ACCUM;
      acc            <= '0;
      count          <= '0;
      sticky_ovf     <= 1'b0;
      out_valid_q    <= 1'b0;
      out_data_q     <= '0;
      out_overflow_q <= 1'b0;
    end else begin
      case (state)
        ACCUM: begin
          if (port.in_valid) begin
            if (count == last_count) begin
              out_data_q     <= sum;
              out_overflow_q <= sticky_ovf | add_ovf;
              out_valid_q    <= 1'b1;
              state          <= HOLD;
              acc            <= '0;
              count          <= '0;
              sticky_ovf     <= 1'b0;
            end else begin
              acc        <= sum;
              count      <= count + count_w'(1);
              sticky_ovf <= sticky_ovf | add_ovf;
            end
          end
        end
        HOLD: begin
          // A beat arriving with the result handoff opens the next group, keeping full throughput.
          if (port.out_ready) begin
            out_valid_q <= 1'b0;
            state       <= ACCUM;
            if (port.in_valid) begin
              acc   <= out_width'(port.in_data);
              count <= count_w'(1);
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sum_stream_accumulator.sv
// Self-checking bench for sum_stream_accumulator: a default-width and a 9-bit-result instance share stimulus.
// Expected overflow behaviour follows SUM_STREAM_ACCUMULATOR_SATURATE_EN.
module tb_sum_stream_accumulator;
  import sum_stream_accumulator_pkg::*;

  localparam int W   = 8;
  localparam int GL  = 4;
  localparam int OW  = 10;
  localparam int OW9 = 9;
`ifdef SUM_STREAM_ACCUMULATOR_SATURATE_EN
  localparam int EXP9_1020 = 511;
`else
  localparam int EXP9_1020 = 508;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] in_data = '0;
  logic         out_ready = 1'b1;

  int tests = 0;
  int fails = 0;

  // Behavioural model: handshake view plus the list of beats of the current group.
  bit m_pending = 1'b0;
  int m_total = 0;
  int grp[$];

  always #5 clk = ~clk;

  sum_stream_accumulator_if #(.width(W), .out_width(OW))  bus ();
  sum_stream_accumulator_if #(.width(W), .out_width(OW9)) bus9 ();

  assign bus.in_valid   = in_valid;
  assign bus.in_data    = in_data;
  assign bus.out_ready  = out_ready;
  assign bus9.in_valid  = in_valid;
  assign bus9.in_data   = in_data;
  assign bus9.out_ready = out_ready;

  sum_stream_accumulator #(.width(W), .group_len(GL), .out_width(OW)) dut (
    .clk  (clk),
    .rst  (rst),
    .port (bus.slave)
  );

  sum_stream_accumulator #(.width(W), .group_len(GL), .out_width(OW9)) dut9 (
    .clk  (clk),
    .rst  (rst),
    .port (bus9.slave)
  );

  function automatic int fold_data(input int total, input int ow);
    int maxv;
    maxv = (1 << ow) - 1;
`ifdef SUM_STREAM_ACCUMULATOR_SATURATE_EN
    return (total > maxv) ? maxv : total;
`else
    return total & maxv;
`endif
  endfunction

  function automatic int fold_ovf(input int total, input int ow);
    return (total > ((1 << ow) - 1)) ? 1 : 0;
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Model update on every active edge, or immediately on reset.
  initial forever begin
    @(posedge clk or negedge rst);
    if (!rst) begin
      m_pending = 1'b0;
      grp.delete();
    end else begin
      bit rdy;
      rdy = !m_pending || out_ready;
      if (m_pending && out_ready) m_pending = 1'b0;
      if (in_valid && rdy) begin
        grp.push_back(int'(in_data));
        if (grp.size() == GL) begin
          m_total   = grp.sum();
          m_pending = 1'b1;
          grp.delete();
        end
      end
    end
  end

  // Compare both instances against the model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (!rst) begin
      check_output("rst_out_valid", {31'b0, bus.out_valid}, 0);
      check_output("rst_out_data", 32'(bus.out_data), 0);
      check_output("rst_out_overflow", {31'b0, bus.out_overflow}, 0);
      check_output("rst_in_ready", {31'b0, bus.in_ready}, 1);
      check_output("rst_out_valid9", {31'b0, bus9.out_valid}, 0);
      check_output("rst_out_data9", 32'(bus9.out_data), 0);
    end else begin
      check_output("in_ready", {31'b0, bus.in_ready}, {31'b0, (!m_pending || out_ready)});
      check_output("out_valid", {31'b0, bus.out_valid}, {31'b0, m_pending});
      check_output("in_ready9", {31'b0, bus9.in_ready}, {31'b0, (!m_pending || out_ready)});
      check_output("out_valid9", {31'b0, bus9.out_valid}, {31'b0, m_pending});
      if (m_pending) begin
        check_output("out_data", 32'(bus.out_data), fold_data(m_total, OW));
        check_output("out_overflow", {31'b0, bus.out_overflow}, fold_ovf(m_total, OW));
        check_output("out_data9", 32'(bus9.out_data), fold_data(m_total, OW9));
        check_output("out_overflow9", {31'b0, bus9.out_overflow}, fold_ovf(m_total, OW9));
      end
    end
  end

  task automatic drive_beat(input int v);
    in_valid = 1'b1;
    in_data  = W'(v);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus();
    int vals[4];
    int k;
    int guard;

    // Power-on reset, released away from the clock edge.
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // 1+2+3+4 back to back: result visible one cycle after the last beat.
    out_ready = 1'b1;
    drive_beat(1); drive_beat(2); drive_beat(3); drive_beat(4);
    in_valid = 1'b0;
    check_output("pin_sum10_valid", {31'b0, bus.out_valid}, 1);
    check_output("pin_sum10_data", 32'(bus.out_data), 10);
    check_output("pin_sum10_ovf", {31'b0, bus.out_overflow}, 0);
    idle(2);

    // Two groups of 4x255 with in_valid held high: no bubble, one result every 4 cycles.
    for (int g = 0; g < 2; g++) begin
      for (int b = 0; b < GL; b++) begin
        check_output("pin_no_bubble", {31'b0, bus.in_ready}, 1);
        drive_beat(255);
      end
      check_output("pin_1020_valid", {31'b0, bus.out_valid}, 1);
      check_output("pin_1020_data", 32'(bus.out_data), 1020);
      check_output("pin_1020_ovf", {31'b0, bus.out_overflow}, 0);
      check_output("pin_ow9_data", 32'(bus9.out_data), EXP9_1020);
      check_output("pin_ow9_ovf", {31'b0, bus9.out_overflow}, 1);
    end
    idle(2);

    // Backpressure: result held for 5 cycles, then handoff with a beat starts the next group at count 1.
    drive_beat(9); drive_beat(9); drive_beat(9);
    out_ready = 1'b0;
    drive_beat(9);
    in_data = W'(50);
    repeat (5) begin
      @(posedge clk);
      #1;
      check_output("pin_hold_data", 32'(bus.out_data), 36);
      check_output("pin_hold_in_ready", {31'b0, bus.in_ready}, 0);
    end
    out_ready = 1'b1;
    drive_beat(3);
    check_output("pin_handoff_valid", {31'b0, bus.out_valid}, 0);
    drive_beat(1); drive_beat(1); drive_beat(1);
    in_valid = 1'b0;
    check_output("pin_count1_valid", {31'b0, bus.out_valid}, 1);
    check_output("pin_count1_data", 32'(bus.out_data), 6);
    idle(2);

    // Asynchronous reset mid-group discards the partial sum.
    drive_beat(7); drive_beat(7);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    drive_beat(1); drive_beat(1); drive_beat(1); drive_beat(1);
    in_valid = 1'b0;
    check_output("pin_after_rst_data", 32'(bus.out_data), 4);

    // Asynchronous reset during HOLD drops the pending result before any clock edge.
    idle(1);
    out_ready = 1'b0;
    drive_beat(9); drive_beat(9); drive_beat(9); drive_beat(9);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    check_output("pin_async_valid", {31'b0, bus.out_valid}, 0);
    check_output("pin_async_data", 32'(bus.out_data), 0);
    @(posedge clk);
    #2 rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check_output("pin_no_stale_result", {31'b0, bus.out_valid}, 0);

    // Beats 5,6,7,8 with random gaps and junk data while in_valid is low.
    vals  = '{5, 6, 7, 8};
    k     = 0;
    guard = 0;
    while (k < 4 && guard < 200) begin
      if ($urandom_range(0, 1) == 1) begin
        in_valid = 1'b1;
        in_data  = W'(vals[k]);
        k++;
      end else begin
        in_valid = 1'b0;
        in_data  = W'($urandom_range(0, 255));
      end
      @(posedge clk);
      #1;
      guard++;
    end
    in_valid = 1'b0;
    check_output("pin_gaps_valid", {31'b0, bus.out_valid}, 1);
    check_output("pin_gaps_data", 32'(bus.out_data), 26);
    idle(2);

    // Random traffic with backpressure and occasional mid-cycle resets.
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 79) == 0) begin
        in_valid = 1'b0;
        #2 rst = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
      end
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = W'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk);
      #1;
    end
    idle(3);
  endtask

  initial begin
    apply_stimulus();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sum_stream_accumulator.md
SUM_STREAM_ACCUMULATOR -- requirements
Module: sum_stream_accumulator

Interface
REQ-001 Parameter width, default 8, is the input beat data width in bits.
REQ-002 Parameter group_len, default 4, is the number of beats per group; legal values are 2..256.
REQ-003 Parameter out_width, default 10, is the accumulator and result width; legal values are out_width >= width.
REQ-004 clk  input  1  is the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  is the reset, asynchronous and active-low.
REQ-006 in_valid  input  1  marks an upstream sum beat as valid.
REQ-007 in_ready  output  1  indicates the block accepts a beat this cycle.
REQ-008 in_data  input  width  carries the sum beat, treated as unsigned.
REQ-009 out_valid  output  1  marks the group result as valid.
REQ-010 out_ready  input  1  indicates downstream accepts the result.
REQ-011 out_data  output  out_width  carries the group total.
REQ-012 out_overflow  output  1  flags that the group total exceeded the out_width range.

Function
REQ-013 A beat SHALL transfer when in_valid & in_ready; a result SHALL transfer when out_valid & out_ready.
REQ-014 The FSM SHALL have exactly two states: ACCUM (collecting beats) and HOLD (result presented).
REQ-015 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-016 Each accepted beat SHALL add in_data, zero-extended to out_width, to the accumulator and SHALL increment the beat counter.
REQ-017 On the accepted beat where count == group_len-1, the next cycle SHALL show out_valid=1, out_data equal to the total including that beat, and state HOLD; the accumulator and counter SHALL be cleared.
REQ-018 Latency from the last accepted beat of a group to out_valid SHALL be exactly 1 cycle.
REQ-019 In HOLD, out_data and out_overflow SHALL stay stable until the result transfers, and in_ready SHALL equal out_ready.
REQ-020 A result transfer with no simultaneous beat SHALL return to ACCUM with count 0.
REQ-021 A result transfer together with a beat transfer SHALL return to ACCUM with accumulator = in_data and count = 1, giving a sustained throughput of group_len cycles per group.
REQ-022 in_valid low mid-group SHALL leave the accumulator and counter unchanged; there is no timeout.
REQ-023 in_data SHALL be ignored when no beat transfer occurs.

Reset
REQ-024 Asserting rst (low) SHALL immediately force state ACCUM, count 0, accumulator 0, out_valid 0, out_data 0 and out_overflow 0, regardless of clock.
REQ-025 A reset mid-group or during HOLD SHALL discard the partial group or pending result; no result from before reset SHALL appear afterwards.
REQ-026 After reset deassertion, in_ready SHALL be 1 in the first cycle.

Configuration
REQ-027 Macro SUM_STREAM_ACCUMULATOR_SATURATE_EN SHALL control how additions that exceed the range are handled.
REQ-028 With the macro defined, additions SHALL saturate at 2^out_width-1, and out_overflow SHALL be 1 if any addition in the group saturated.
REQ-029 With the macro undefined, additions SHALL wrap modulo 2^out_width, and out_overflow SHALL be 1 if any addition in the group produced a carry out.

Structure
REQ-030 Package sum_stream_accumulator_pkg SHALL hold the FSM state typedef (ACCUM, HOLD) and the default parameter constants.
REQ-031 The counter width SHALL be $clog2(group_len).
REQ-032 One sub-module, sum_stream_acc_adder, SHALL implement the add/saturate/overflow-detect datapath, including the macro-dependent logic.

Verification
REQ-033 Defaults; beats 1,2,3,4 back-to-back with out_ready=1 -> out_data=10, out_overflow=0, out_valid 1 cycle after beat 4.
REQ-034 Defaults; two groups of 4×255 with out_ready=1 and in_valid held 1 -> two results of 1020, no bubble on in_ready, one result every 4 cycles.
REQ-035 Defaults; out_ready=0 for 5 cycles after a result -> out_data held stable, in_ready=0, no beats accepted; out_ready=1 with in_valid=1 -> next group starts with count 1.
REQ-036 out_width=9; 4×255 -> without macro out_data=508 and out_overflow=1; with macro out_data=511 and out_overflow=1.
REQ-037 Defaults; beats 7,7, then rst low asynchronously between clock edges, then beats 1,1,1,1 -> first result is 4, and outputs are zero while rst is low.
REQ-038 Defaults; in_valid toggled randomly with beats 5,6,7,8 -> out_data=26, and gaps do not corrupt the count.
